// File: rtl/mult_div_unit_pkg.sv
// Shared MDU constants: op codes, default latencies and the arithmetic result payload.
package mult_div_unit_pkg;

   localparam int unsigned XLEN            = 32;
   localparam int unsigned MULT_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF  = 10;

   typedef enum logic [2:0] {
      MDU_NONE  = 3'd0,
      MDU_MULT  = 3'd1,
      MDU_MULTU = 3'd2,
      MDU_DIV   = 3'd3,
      MDU_DIVU  = 3'd4,
      MDU_MTHI  = 3'd5,
      MDU_MTLO  = 3'd6,
      MDU_RSVD  = 3'd7
   } mdu_op_e;

   typedef struct packed {
      logic [XLEN-1:0] hi;
      logic [XLEN-1:0] lo;
      logic            div_by_zero;
   } mdu_res_t;

   // True for the ops that launch a multi-cycle operation; reserved code decodes as NONE.
   function automatic logic is_start(input logic [2:0] op);
      return (op == MDU_MULT) || (op == MDU_MULTU) ||
             (op == MDU_DIV)  || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mult_div_unit_arith.sv
// Combinational datapath of the MDU (the mdu_arith block): product, quotient/remainder, div-by-zero flag.
module mult_div_unit_arith
   import mult_div_unit_pkg::*;
(
   input  logic [2:0]      i_op,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   output mdu_res_t        o_res_c
);

   localparam int unsigned PW = 2 * XLEN;

   logic [PW-1:0]   w_prod_s;
   logic [PW-1:0]   w_prod_u;
   logic            w_div_zero;
   logic [XLEN-1:0] w_mag_a;
   logic [XLEN-1:0] w_mag_b;
   logic [XLEN-1:0] w_uq;
   logic [XLEN-1:0] w_ur;
   logic [XLEN-1:0] w_sq;
   logic [XLEN-1:0] w_sr;
   logic [XLEN-1:0] w_dvsr_u;
   logic [XLEN-1:0] w_dq;
   logic [XLEN-1:0] w_dr;

   // Signed ops use sign magnitudes so 0x80000000 / -1 wraps to 0x80000000 with remainder 0.
   always_comb begin
      w_prod_s   = {{XLEN{i_a[XLEN-1]}}, i_a} * {{XLEN{i_b[XLEN-1]}}, i_b};
      w_prod_u   = {{XLEN{1'b0}}, i_a} * {{XLEN{1'b0}}, i_b};
      w_div_zero = (i_b == '0);
      w_dvsr_u   = w_div_zero ? XLEN'(1) : i_b;
      w_mag_a    = i_a[XLEN-1] ? -i_a : i_a;
      w_mag_b    = w_div_zero ? XLEN'(1) : (i_b[XLEN-1] ? -i_b : i_b);
      w_uq       = w_mag_a / w_mag_b;
      w_ur       = w_mag_a % w_mag_b;
      w_sq       = (i_a[XLEN-1] ^ i_b[XLEN-1]) ? -w_uq : w_uq;
      w_sr       = i_a[XLEN-1] ? -w_ur : w_ur;
      w_dq       = i_a / w_dvsr_u;
      w_dr       = i_a % w_dvsr_u;
   end

   // Select the result pair for the current op.
   always_comb begin
      o_res_c = '0;
      case (i_op)
         MDU_MULT:  begin
            o_res_c.hi = w_prod_s[PW-1:XLEN];
            o_res_c.lo = w_prod_s[XLEN-1:0];
         end
         MDU_MULTU: begin
            o_res_c.hi = w_prod_u[PW-1:XLEN];
            o_res_c.lo = w_prod_u[XLEN-1:0];
         end
         MDU_DIV:   begin
            o_res_c.hi          = w_sr;
            o_res_c.lo          = w_sq;
            o_res_c.div_by_zero = w_div_zero;
         end
         MDU_DIVU:  begin
            o_res_c.hi          = w_dr;
            o_res_c.lo          = w_dq;
            o_res_c.div_by_zero = w_div_zero;
         end
         default:   o_res_c = '0;
      endcase
   end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: owns HI/LO, runs fixed-latency ops, handles MTHI/MTLO ordering.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
)(
   input  logic            clk,
   input  logic            reset_n,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            start,
   output logic            busy,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

   mdu_res_t        w_res;
   logic            w_start;
   logic            w_is_mul;

   logic            r_busy;
   logic [CNT_W-1:0] r_cnt;
   logic [XLEN-1:0] r_hold_hi;
   logic [XLEN-1:0] r_hold_lo;
   logic            r_hold_dz;
   logic            r_skip_hi;
   logic            r_skip_lo;
   logic [XLEN-1:0] r_hi;
   logic [XLEN-1:0] r_lo;

   mult_div_unit_arith u_arith (
      .i_op    (op),
      .i_a     (a),
      .i_b     (b),
      .o_res_c (w_res)
   );

   assign w_start  = is_start(op);
   assign w_is_mul = (op == MDU_MULT) || (op == MDU_MULTU);
   assign start    = w_start;
   assign busy     = r_busy;
   assign hi       = r_hi;
   assign lo       = r_lo;

   // Launch, count down and commit; MT writes come last so they win over a same-edge commit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_busy    <= 1'b0;
         r_cnt     <= '0;
         r_hold_hi <= '0;
         r_hold_lo <= '0;
         r_hold_dz <= 1'b0;
         r_skip_hi <= 1'b0;
         r_skip_lo <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
      end else begin
         if (r_busy) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
               r_busy <= 1'b0;
               if (!r_hold_dz && !r_skip_hi) r_hi <= r_hold_hi;
               if (!r_hold_dz && !r_skip_lo) r_lo <= r_hold_lo;
            end
         end else if (w_start) begin
            r_hold_hi <= w_res.hi;
            r_hold_lo <= w_res.lo;
            r_hold_dz <= w_res.div_by_zero;
            r_cnt     <= w_is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            r_busy    <= 1'b1;
            r_skip_hi <= 1'b0;
            r_skip_lo <= 1'b0;
         end

         if (op == MDU_MTHI) begin
            r_hi <= a;
            if (r_busy) r_skip_hi <= 1'b1;
         end
         if (op == MDU_MTLO) begin
            r_lo <= a;
            if (r_busy) r_skip_lo <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed scoreboard bench for mult_div_unit.
module tb_mult_div_unit;
   import mult_div_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        start;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_chk     = 0;
   int n_pass    = 0;
   int n_illegal = 0;
   logic [63:0] q_exp[$];

   mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .op      (op),
      .a       (a),
      .b       (b),
      .start   (start),
      .busy    (busy),
      .hi      (hi),
      .lo      (lo)
   );

   always #5 clk = ~clk;

   // Protocol monitor: a launch request while busy must never be accepted silently.
   always @(posedge clk) begin
      if (reset_n && start && busy) n_illegal++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   // Issue one op, optionally inject another op in busy cycle inj_cyc, then check latency and result.
   task automatic run_op(input string tag, input logic [2:0] t_op, input logic [31:0] t_a,
                         input logic [31:0] t_b, input logic [63:0] t_exp, input int t_cyc,
                         input logic [2:0] inj_op, input int inj_cyc,
                         input logic [31:0] inj_a, input logic [31:0] inj_b);
      logic [63:0] e;
      int cyc;
      q_exp.push_back(t_exp);
      @(negedge clk);
      op = t_op; a = t_a; b = t_b;
      #1 chk({tag, "_start"}, 32'(start), 32'd1);
      @(posedge clk);
      #1 op = MDU_NONE; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
      cyc = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (op != MDU_NONE) begin
            if (op == MDU_MTLO) chk({tag, "_mtlo_now"}, lo, inj_a);
            if (op == MDU_MTHI) chk({tag, "_mthi_now"}, hi, inj_a);
            op = MDU_NONE;
         end
         if (!busy) break;
         cyc++;
         if (cyc == inj_cyc) begin
            op = inj_op; a = inj_a; b = inj_b;
         end
      end
      chk({tag, "_busy_cycles"}, 32'(cyc), 32'(t_cyc));
      e = q_exp.pop_front();
      chk({tag, "_hi"}, hi, e[63:32]);
      chk({tag, "_lo"}, lo, e[31:0]);
   endtask

   // Single MTHI/MTLO while idle.
   task automatic mt(input string tag, input logic [2:0] t_op, input logic [31:0] v);
      @(negedge clk);
      op = t_op; a = v;
      #1 chk({tag, "_start"}, 32'(start), 32'd0);
      @(posedge clk);
      #1 op = MDU_NONE;
      @(negedge clk);
      chk(tag, (t_op == MDU_MTHI) ? hi : lo, v);
   endtask

   initial begin
      reset_n = 1'b0;
      op = MDU_NONE; a = '0; b = '0;
      repeat (2) @(negedge clk);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);

      for (int v = 0; v < 8; v++) begin
         op = 3'(v);
         #1 chk($sformatf("decode_op%0d", v), 32'(start), (v >= 1 && v <= 4) ? 32'd1 : 32'd0);
      end
      op = MDU_NONE;
      @(negedge clk);
      reset_n = 1'b1;

      run_op("mult_neg", MDU_MULT,  32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 5, MDU_NONE, 0, 0, 0);
      run_op("div_neg",  MDU_DIV,   32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 10, MDU_NONE, 0, 0, 0);
      run_op("divu",     MDU_DIVU,  32'd7,         32'd2, 64'h0000_0001_0000_0003, 10, MDU_NONE, 0, 0, 0);
      run_op("div_ovf",  MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 10, MDU_NONE, 0, 0, 0);
      run_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 5, MDU_NONE, 0, 0, 0);

      mt("mthi", MDU_MTHI, 32'h11);
      mt("mtlo", MDU_MTLO, 32'h22);
      run_op("divu_zero", MDU_DIVU, 32'd5, 32'd0, 64'h0000_0011_0000_0022, 10, MDU_NONE, 0, 0, 0);

      run_op("mt_busy", MDU_MULTU, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_ABCD, 5,
             MDU_MTLO, 2, 32'h0000_ABCD, 32'd0);

      run_op("start_busy", MDU_MULT, 32'd2, 32'd3, 64'h0000_0000_0000_0006, 5,
             MDU_DIV, 1, 32'd9, 32'd3);
      chk("illegal_start_seen", 32'(n_illegal), 32'd1);

      // Asynchronous reset in the middle of a divide.
      @(negedge clk);
      op = MDU_DIV; a = 32'd100; b = 32'd7;
      @(posedge clk);
      #1 op = MDU_NONE;
      repeat (4) @(negedge clk);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_hi", hi, 32'd0);
      chk("async_rst_lo", lo, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_hi", hi, 32'd0);
      chk("post_rst_lo", lo, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
